// File: rtl/seven_seg_scanner_pkg.sv
// Shared types, constants and the hex decoder for the seven-segment scanner.
// Optional feature macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN (used in seven_seg_scanner.sv).
package seven_seg_pkg;

  // Active-low cathodes, {g,f,e,d,c,b,a}
  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_OFF    = 7'h7F;
  localparam logic [3:0] ANODES_OFF = 4'hF;

  // Hex value to active-low segment pattern (lower-case b and d)
  function automatic seg_t hex_to_seg(input logic [3:0] value);
    seg_t seg;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Bundle of the digit value/enable pairs and the display drive lines between the
// game controller (master) and the display scanner (slave).
interface seven_seg_scanner_if;
  import seven_seg_pkg::*;

  logic       digit0_en;
  logic [3:0] digit0;
  logic       digit1_en;
  logic [3:0] digit1;
  logic       digit2_en;
  logic [3:0] digit2;
  logic       digit3_en;
  logic [3:0] digit3;
  logic [3:0] anode;
  seg_t       segments;

  modport master (
    output digit0_en, digit0, digit1_en, digit1,
           digit2_en, digit2, digit3_en, digit3,
    input  anode, segments
  );

  modport slave (
    input  digit0_en, digit0, digit1_en, digit1,
           digit2_en, digit2, digit3_en, digit3,
    output anode, segments
  );

endinterface

// File: rtl/seven_seg_scanner_timer.sv
// Slot timing: cnt runs 0..REFRESH_DIV-1 per digit slot, sel picks the digit
// round-robin and advances on each wrap.
module scan_timer
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       slot_start_o,
  output logic       blank_o,
  output logic [1:0] sel_o
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;

  // Next slot position and digit select
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end
  end

  // Counter and select registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign slot_start_o = (cnt_q == '0);
  assign blank_o      = (cnt_q < CNT_BLANK);
  assign sel_o        = sel_q;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes four hex digits onto a common-anode 4-digit display.
// Optional feature macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks a zero tens digit
// (digits 1 and 3) so paired values like "05" show as " 5".
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       digit0_en_i,
  input  logic [3:0] digit0_i,
  input  logic       digit1_en_i,
  input  logic [3:0] digit1_i,
  input  logic       digit2_en_i,
  input  logic [3:0] digit2_i,
  input  logic       digit3_en_i,
  input  logic [3:0] digit3_i,
  output logic [3:0] anode_o,
  output seg_t       segments_o
);

  if (REFRESH_DIV < BLANK_CYCLES + 2) begin : g_bad_div
    $error("seven_seg_scanner: REFRESH_DIV must be >= BLANK_CYCLES+2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seven_seg_scanner: BLANK_CYCLES must be >= 1");
  end

  logic       slot_start;
  logic       blank;
  logic [1:0] sel;

  scan_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .slot_start_o (slot_start),
    .blank_o      (blank),
    .sel_o        (sel)
  );

  logic       en_mux;
  logic [3:0] val_mux;
  logic       snap_en_q, snap_en_d;
  logic [3:0] snap_val_q, snap_val_d;
  logic [3:0] anode_q, anode_d;
  seg_t       seg_q, seg_d;

  // Select the digit owning the current slot
  always_comb begin
    en_mux  = digit0_en_i;
    val_mux = digit0_i;
    case (sel)
      2'd1: begin en_mux = digit1_en_i; val_mux = digit1_i; end
      2'd2: begin en_mux = digit2_en_i; val_mux = digit2_i; end
      2'd3: begin en_mux = digit3_en_i; val_mux = digit3_i; end
      default: ;
    endcase
  end

  // Snapshot the slot's digit once at slot start so mid-slot changes cannot tear
  always_comb begin
    snap_en_d  = snap_en_q;
    snap_val_d = snap_val_q;
    if (slot_start) begin
      snap_en_d  = en_mux;
      snap_val_d = val_mux;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      // Odd select = tens digit of a pair; a zero there is shown dark
      if (sel[0] && (val_mux == 4'h0)) begin
        snap_en_d = 1'b0;
      end
`endif
    end
  end

  // Output decode: dark during the blanking lead-in or for a disabled digit
  always_comb begin
    anode_d = ANODES_OFF;
    seg_d   = SEG_OFF;
    if (!blank && snap_en_q) begin
      anode_d = ~(4'b0001 << sel);
      seg_d   = hex_to_seg(snap_val_q);
    end
  end

  // Snapshot and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_en_q  <= 1'b0;
      snap_val_q <= '0;
      anode_q    <= ANODES_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      snap_en_q  <= snap_en_d;
      snap_val_q <= snap_val_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

  assign anode_o    = anode_q;
  assign segments_o = seg_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scanner;

  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scanner_if dif ();

  seven_seg_scanner #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .digit0_en_i (dif.digit0_en),
    .digit0_i    (dif.digit0),
    .digit1_en_i (dif.digit1_en),
    .digit1_i    (dif.digit1),
    .digit2_en_i (dif.digit2_en),
    .digit2_i    (dif.digit2),
    .digit3_en_i (dif.digit3_en),
    .digit3_i    (dif.digit3),
    .anode_o     (dif.anode),
    .segments_o  (dif.segments)
  );

  // Hand-written decode table, active-low {g..a}
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference slot model
  int unsigned m_cnt = 0;
  int unsigned m_sel = 0;
  logic        m_en  = 1'b0;
  logic [3:0]  m_val = '0;

  // Advance one clock and compare outputs with the reference model
  task automatic step(input string tag);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       en;
    logic [3:0] val;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    if (!rst && m_cnt >= BLANK && m_en) begin
      exp_an  = ~(4'b0001 << m_sel);
      exp_seg = seg_tbl[m_val];
    end
    if (rst) begin
      m_cnt = 0;
      m_sel = 0;
      m_en  = 1'b0;
      m_val = '0;
    end else begin
      if (m_cnt == 0) begin
        case (m_sel)
          0: begin en = dif.digit0_en; val = dif.digit0; end
          1: begin en = dif.digit1_en; val = dif.digit1; end
          2: begin en = dif.digit2_en; val = dif.digit2; end
          default: begin en = dif.digit3_en; val = dif.digit3; end
        endcase
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if ((m_sel % 2) == 1 && val == 4'h0) en = 1'b0;
`endif
        m_en  = en;
        m_val = val;
      end
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_sel = (m_sel + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_anode"}, 32'(dif.anode), 32'(exp_an));
    check({tag, "_seg"}, 32'(dif.segments), 32'(exp_seg));
  endtask

  task automatic run(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(tag);
  endtask

  // Step until the model sits at the given slot position (bounded by one frame)
  task automatic run_to(input string tag, input int unsigned sel, input int unsigned cnt);
    for (int unsigned i = 0; i < 4 * DIV; i++) begin
      if (m_sel == sel && m_cnt == cnt) return;
      step(tag);
    end
    check({tag, "_reach"}, 32'(m_cnt), 32'(cnt));
  endtask

  initial begin
    dif.digit0_en = 1'b1; dif.digit0 = 4'h8;
    dif.digit1_en = 1'b1; dif.digit1 = 4'h1;
    dif.digit2_en = 1'b1; dif.digit2 = 4'h2;
    dif.digit3_en = 1'b1; dif.digit3 = 4'hF;

    // 1. Reset held 3 cycles
    run("reset", 3);
    rst = 1'b0;

    // 2. Full frames F,2,1,8; first lit slot must be digit 0
    run("scan", 2 * 4 * DIV);
    run_to("seek", 0, 5);
    check("slot0_lit_anode", 32'(dif.anode), 32'h0000000E);
    check("slot0_lit_seg", 32'(dif.segments), 32'h00000000);
    run_to("seek", 3, 5);
    check("slot3_lit_anode", 32'(dif.anode), 32'h00000007);
    check("slot3_lit_seg", 32'(dif.segments), 32'h0000000E);

    // 3. Digit 2 disabled: slot dark but still consumed
    dif.digit2_en = 1'b0;
    run("dis2", 2 * 4 * DIV);
    run_to("seek", 2, 5);
    check("slot2_dark_anode", 32'(dif.anode), 32'h0000000F);
    dif.digit2_en = 1'b1;

    // 4. Mid-slot change of digit 0 does not tear
    dif.digit0 = 4'h1;
    run_to("seek", 0, 4);
    dif.digit0 = 4'h7;
    run_to("tear", 1, 0);
    check("tear_held_seg", 32'(dif.segments), 32'h00000079);
    run_to("tear2", 0, 5);
    check("tear_next_seg", 32'(dif.segments), 32'h00000078);

    // 5. Reset mid-slot 2, then restart at digit 0
    run_to("seek", 2, 4);
    rst = 1'b1;
    step("midrst");
    check("midrst_anode", 32'(dif.anode), 32'h0000000F);
    rst = 1'b0;
    run("postrst", 4 * DIV);

    // 6. Paired digits with a zero tens digit
    dif.digit1 = 4'h0; dif.digit0 = 4'h5;
    run_to("lz", 1, 0);
    run("lz_a", 4 * DIV);
    run_to("seek", 1, 5);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    check("lz_tens_anode", 32'(dif.anode), 32'h0000000F);
`else
    check("lz_tens_seg", 32'(dif.segments), 32'h00000040);
`endif
    run_to("seek", 0, 5);
    check("lz_ones_seg", 32'(dif.segments), 32'h00000012);
    dif.digit0 = 4'h0;
    run("lz_b", 4 * DIV);
    run_to("seek", 0, 5);
    check("lz_zero_seg", 32'(dif.segments), 32'h00000040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
